// File: rtl/instr_dec_pkg.sv
// Shared constants for the instruction-decoder bank: stack opcodes, decoder ids,
// parked-bus values and the issue controller state encoding.
package instr_dec_pkg;

  localparam logic [4:0] OPC_PUSH = 5'b01011;
  localparam logic [4:0] OPC_POP  = 5'b01100;

  localparam logic [2:0] ID_DEC0 = 3'b000;
  localparam logic [2:0] ID_DEC1 = 3'b001;
  localparam logic [2:0] ID_DEC2 = 3'b010;
  localparam logic [2:0] ID_DEC3 = 3'b011;

  localparam logic [2:0] PARK_ID    = 3'b000;
  localparam logic [4:0] PARK_INSTR = 5'b00000;
  localparam logic       PARK_CC    = 1'b0;
  localparam logic       PARK_EN_N  = 1'b1;

  // Issue controller FSM states, kept as plain constants for legacy tools.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_BUBBLE = 2'd2;

  function automatic logic is_stack_op(input logic [4:0] instr);
    return (instr == OPC_PUSH) || (instr == OPC_POP);
  endfunction

endpackage

// File: rtl/issue_hold_cnt.sv
// Loadable down-counter that sets how long an instruction stays on the decoder bus.
// last is high while the count sits at zero; freeze holds the count.
module issue_hold_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       freeze,
  output logic       last
);

  logic [3:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (!freeze && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign last = (count == 4'd0);

endmodule

// File: rtl/instr_issue_ctrl.sv
// Issue controller for the decoder bank: handshake, bus hold, post-stack bubble, stack tracking.
// Optional macro INSTR_ISSUE_CC_SYNC_EN routes cc_in through a two-flop synchronizer.
module instr_issue_ctrl
  import instr_dec_pkg::*;
#(
  parameter int ISSUE_CYCLES = 1,
  parameter int STACK_DEPTH  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_word,
  input  logic       cc_in,
  input  logic       dp_stall,
  output logic [2:0] dec_id,
  output logic [4:0] dec_instr,
  output logic       dec_cc,
  output logic       dec_en_n,
  output logic [3:0] stack_depth,
  output logic       err_ovf,
  output logic       err_unf,
  input  logic       err_clr,
  output logic       busy
);

  localparam logic [3:0] HOLD_LOAD = 4'(ISSUE_CYCLES - 1);
  localparam logic [3:0] DEPTH_MAX = 4'(STACK_DEPTH);

  logic [1:0] state, state_nxt;
  logic [2:0] cmd_id;
  logic [4:0] cmd_instr;
  logic       cc_cap;
  logic       hold_last, hold_freeze;
  logic       exit_ok, cur_stack;
  logic       accept, accept_legal;
  logic       is_push, is_pop, push_ovf, pop_unf;

  assign cmd_id    = cmd_word[7:5];
  assign cmd_instr = cmd_word[4:0];

`ifdef INSTR_ISSUE_CC_SYNC_EN
  logic cc_meta, cc_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_meta <= 1'b0;
      cc_sync <= 1'b0;
    end else begin
      cc_meta <= cc_in;
      cc_sync <= cc_meta;
    end
  end

  assign cc_cap = cc_sync;
`else
  assign cc_cap = cc_in;
`endif

  assign hold_freeze = dp_stall || (state != ST_ISSUE);

  issue_hold_cnt u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept_legal),
    .load_val (HOLD_LOAD),
    .freeze   (hold_freeze),
    .last     (hold_last)
  );

  // A stack op in flight owes a bubble, so it cannot hand over to a new command.
  always_comb begin
    cur_stack    = is_stack_op(dec_instr);
    exit_ok      = (state == ST_ISSUE) && hold_last && !dp_stall;
    cmd_ready    = (state == ST_IDLE) || (exit_ok && !cur_stack);
    accept       = cmd_valid && cmd_ready;
    is_push      = (cmd_instr == OPC_PUSH);
    is_pop       = (cmd_instr == OPC_POP);
    push_ovf     = accept && is_push && (stack_depth == DEPTH_MAX);
    pop_unf      = accept && is_pop && (stack_depth == 4'd0);
    accept_legal = accept && !push_ovf && !pop_unf;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept_legal) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (exit_ok) begin
          if (cur_stack)         state_nxt = ST_BUBBLE;
          else if (accept_legal) state_nxt = ST_ISSUE;
          else                   state_nxt = ST_IDLE;
        end
      end
      ST_BUBBLE: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_id    <= PARK_ID;
      dec_instr <= PARK_INSTR;
      dec_cc    <= PARK_CC;
      dec_en_n  <= PARK_EN_N;
    end else if (accept_legal) begin
      dec_id    <= cmd_id;
      dec_instr <= cmd_instr;
      dec_cc    <= cc_cap;
      dec_en_n  <= 1'b0;
    end else if (state_nxt != ST_ISSUE) begin
      dec_id    <= PARK_ID;
      dec_instr <= PARK_INSTR;
      dec_cc    <= PARK_CC;
      dec_en_n  <= PARK_EN_N;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stack_depth <= 4'd0;
    end else if (accept_legal && is_push) begin
      stack_depth <= stack_depth + 4'd1;
    end else if (accept_legal && is_pop) begin
      stack_depth <= stack_depth - 4'd1;
    end
  end

  // A fresh rejection outranks a clear arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      err_ovf <= push_ovf || (err_ovf && !err_clr);
      err_unf <= pop_unf || (err_unf && !err_clr);
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Scoreboard bench for instr_issue_ctrl: a cycle-budget reference model predicts handshake,
// stack and flag behaviour and queues expected bus words; a monitor checks what the bus shows.
module tb_instr_issue_ctrl;

  localparam int ISSUE_CYCLES = 3;
  localparam int STACK_DEPTH  = 8;
  localparam logic [4:0] PUSH = 5'b01011;
  localparam logic [4:0] POP  = 5'b01100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_word = 8'h00;
  logic       cc_in = 1'b0;
  logic       dp_stall = 1'b0;
  logic       err_clr = 1'b0;
  logic       cmd_ready;
  logic [2:0] dec_id;
  logic [4:0] dec_instr;
  logic       dec_cc;
  logic       dec_en_n;
  logic [3:0] stack_depth;
  logic       err_ovf;
  logic       err_unf;
  logic       busy;

  instr_issue_ctrl #(
    .ISSUE_CYCLES (ISSUE_CYCLES),
    .STACK_DEPTH  (STACK_DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_word    (cmd_word),
    .cc_in       (cc_in),
    .dp_stall    (dp_stall),
    .dec_id      (dec_id),
    .dec_instr   (dec_instr),
    .dec_cc      (dec_cc),
    .dec_en_n    (dec_en_n),
    .stack_depth (stack_depth),
    .err_ovf     (err_ovf),
    .err_unf     (err_unf),
    .err_clr     (err_clr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Expected bus words {id, instr, cc}, one per legal accept.
  logic [8:0] exp_q[$];

  // Reference model: remaining unstalled hold cycles, pending bubble, occupancy, flags.
  int  m_rem = 0;
  int  m_depth = 0;
  bit  m_bubble = 1'b0;
  bit  m_stack = 1'b0;
  bit  m_ovf = 1'b0;
  bit  m_unf = 1'b0;
  bit  m_acc = 1'b0;
  bit  m_cc_d1 = 1'b0;
  bit  m_cc_d2 = 1'b0;

  bit         mon_active = 1'b0;
  int         mon_n = 0;
  logic [8:0] mon_exp = 9'h000;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  // The model looks at the cycle's inputs and predicts the next edge.
  always @(negedge clk) begin : model
    bit ready, is_push, is_pop, cc_acc, new_ovf, new_unf;
    if (!rst_n) begin
      m_rem = 0; m_depth = 0; m_bubble = 0; m_stack = 0;
      m_ovf = 0; m_unf = 0; m_acc = 0; m_cc_d1 = 0; m_cc_d2 = 0;
      exp_q.delete();
    end else begin
      check_output("stack_depth", stack_depth, m_depth);
      check_output("err_ovf", err_ovf, m_ovf);
      check_output("err_unf", err_unf, m_unf);
      check_output("busy", busy, (m_rem > 0) || m_bubble);
      check_output("dec_en_n", dec_en_n, !(m_rem > 0));
      ready = (m_rem == 0 && !m_bubble) || (m_rem == 1 && !dp_stall && !m_stack);
      check_output("cmd_ready", cmd_ready, ready);
      m_acc = cmd_valid && ready;
`ifdef INSTR_ISSUE_CC_SYNC_EN
      cc_acc = m_cc_d2;
`else
      cc_acc = cc_in;
`endif
      new_ovf = 0;
      new_unf = 0;
      if (m_bubble) begin
        m_bubble = 0;
      end else if (m_rem > 0 && !dp_stall) begin
        m_rem--;
        if (m_rem == 0 && m_stack) m_bubble = 1;
      end
      if (m_acc) begin
        is_push = (cmd_word[4:0] == PUSH);
        is_pop  = (cmd_word[4:0] == POP);
        if (is_push && m_depth == STACK_DEPTH) new_ovf = 1;
        else if (is_pop && m_depth == 0) new_unf = 1;
        else begin
          if (is_push) m_depth++;
          if (is_pop) m_depth--;
          m_rem = ISSUE_CYCLES;
          m_stack = is_push || is_pop;
          exp_q.push_back({cmd_word, cc_acc});
        end
      end
      m_ovf = new_ovf || (m_ovf && !err_clr);
      m_unf = new_unf || (m_unf && !err_clr);
      m_cc_d2 = m_cc_d1;
      m_cc_d1 = cc_in;
    end
  end

  // Each issue occupies ISSUE_CYCLES unstalled cycles with a constant bus word.
  always @(negedge clk) begin : monitor
    if (!rst_n) begin
      mon_active = 0;
    end else if (dec_en_n == 1'b0) begin
      if (!mon_active) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_issue: got bus 0x%0h, expected no issue at %0t",
                   {dec_id, dec_instr, dec_cc}, $time);
        end else begin
          mon_exp = exp_q.pop_front();
          mon_active = 1;
          mon_n = 0;
        end
      end
      if (mon_active) begin
        check_output("issue_bus", {dec_id, dec_instr, dec_cc}, mon_exp);
        if (!dp_stall) mon_n++;
        if (mon_n == ISSUE_CYCLES) mon_active = 0;
      end
    end else begin
      if (mon_active) begin
        checks++;
        $display("[TB] FAIL issue_cut_short: got %0d unstalled cycles, expected %0d at %0t",
                 mon_n, ISSUE_CYCLES, $time);
        mon_active = 0;
      end
      check_output("parked_bus", {dec_id, dec_instr, dec_cc}, 9'h000);
    end
  end

  task automatic apply_stimulus(input logic v, input logic [7:0] w, input logic cc,
                                input logic st, input logic clr);
    @(posedge clk);
    #1;
    cmd_valid = v;
    cmd_word  = w;
    cc_in     = cc;
    dp_stall  = st;
    err_clr   = clr;
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // Holds the command until the model sees it taken; called at posedge+1.
  task automatic send_cmd(input logic [7:0] w, input logic cc);
    bit done;
    done = 0;
    cmd_valid = 1'b1;
    cmd_word  = w;
    cc_in     = cc;
    dp_stall  = 1'b0;
    err_clr   = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(posedge clk);
      if (m_acc) done = 1;
    end
    #1;
    cmd_valid = 1'b0;
    if (!done) begin
      checks++;
      $display("[TB] FAIL accept_timeout: got no accept of 0x%0h, expected one within 64 cycles", w);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    send_cmd(8'h48, 1'b1);
    idle(5);

    send_cmd(8'h49, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle(6);

    send_cmd(8'h4C, 1'b0);
    idle(2);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(2);

    for (int i = 0; i < 9; i++) send_cmd(8'h4B, 1'($unsigned(i) & 1));
    idle(4);

    send_cmd(8'h48, 1'b0);
    send_cmd(8'h49, 1'b1);
    send_cmd(8'h4A, 1'b0);
    idle(4);

    send_cmd(8'h8C, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_bus", {dec_id, dec_instr, dec_cc, dec_en_n}, 10'h001);
    check_output("rst_depth", stack_depth, 0);
    check_output("rst_flags", {err_ovf, err_unf, busy}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    send_cmd(8'h48, 1'b1);
    idle(5);

    for (int i = 0; i < 500; i++) begin
      logic [7:0] w;
      int r;
      r = $urandom_range(0, 9);
      w[7:5] = 3'($urandom_range(0, 7));
      w[4:0] = (r < 3) ? PUSH : (r < 6) ? POP : 5'($urandom_range(0, 31));
      apply_stimulus($urandom_range(0, 2) != 0, w, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
    end
    idle(12);
    check_output("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
